// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver state encoding and bit-timing helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - received-byte strobe bundle; ferr exists only with UART_RX_FRAME_CHECK_EN
interface uart_receiver_if;
    logic [7:0] tdata;
    logic       tvalid;
`ifdef UART_RX_FRAME_CHECK_EN
    logic       ferr;
`endif

    modport master (
        output tdata,
        output tvalid
`ifdef UART_RX_FRAME_CHECK_EN
        ,
        output ferr
`endif
    );

    modport slave (
        input tdata,
        input tvalid
`ifdef UART_RX_FRAME_CHECK_EN
        ,
        input ferr
`endif
    );
endinterface

// File: rtl/uart_receiver_core.sv
// rtl/uart_receiver_core.sv - 8N1 framing FSM on the synchronized line; UART_RX_FRAME_CHECK_EN gates bad-stop bytes
module uart_receiver_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_s,
    uart_receiver_if.master rx_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_START     = START;
    localparam logic [2:0] ST_DATA      = DATA;
    localparam logic [2:0] ST_STOP      = STOP;
    localparam logic [2:0] ST_WAIT_HIGH = WAIT_HIGH;

    logic [2:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_out.tdata  <= '0;
            rx_out.tvalid <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            rx_out.ferr   <= 1'b0;
`endif
        end else begin
            rx_out.tvalid <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            rx_out.ferr   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        clk_cnt <= '0;
                    end
                end
                ST_START: begin
                    // A start bit that is gone by mid-bit was a glitch
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt        <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // Leave at mid-stop so the next start edge is not missed
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
`ifdef UART_RX_FRAME_CHECK_EN
                        if (rx_s) begin
                            rx_out.tdata  <= shreg;
                            rx_out.tvalid <= 1'b1;
                        end else begin
                            rx_out.ferr   <= 1'b1;
                        end
`else
                        rx_out.tdata  <= shreg;
                        rx_out.tvalid <= 1'b1;
`endif
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver_sync2.sv
// rtl/uart_receiver_sync2.sv - two-flop synchronizer with configurable reset value
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver top, drop-in for uart_rec; Rx_ferr port only with UART_RX_FRAME_CHECK_EN
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       CLOCK_50,
    input  logic       Rx,
    input  logic       reset,
    output logic [7:0] Rx_Data,
    output logic       Rx_dval
`ifdef UART_RX_FRAME_CHECK_EN
    ,
    output logic       Rx_ferr
`endif
);

    logic rx_s;

    uart_receiver_if rx_bus ();

    sync2 #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .d     (Rx),
        .q     (rx_s)
    );

    uart_receiver_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk    (CLOCK_50),
        .reset  (reset),
        .rx_s   (rx_s),
        .rx_out (rx_bus.master)
    );

    assign Rx_Data = rx_bus.tdata;
    assign Rx_dval = rx_bus.tvalid;
`ifdef UART_RX_FRAME_CHECK_EN
    assign Rx_ferr = rx_bus.ferr;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed table and sequence bench for uart_receiver, both UART_RX_FRAME_CHECK_EN builds
module tb_uart_receiver;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    int   cyc = 0;

    uart_receiver_if bus ();

    uart_receiver #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .CLOCK_50 (clk),
        .Rx       (rx),
        .reset    (reset),
        .Rx_Data  (bus.tdata),
        .Rx_dval  (bus.tvalid)
`ifdef UART_RX_FRAME_CHECK_EN
        ,
        .Rx_ferr  (bus.ferr)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         failures = 0;
    int         dval_cnt = 0;
    int         ferr_cnt = 0;
    int         consec = 0;
    int         last_dval_cyc = 0;
    logic       prev_dval = 1'b0;
    logic [7:0] got[$];

    always @(negedge clk) begin
        if (bus.tvalid === 1'b1) begin
            dval_cnt++;
            got.push_back(bus.tdata);
            last_dval_cyc = cyc;
            if (prev_dval) consec++;
        end
        prev_dval = (bus.tvalid === 1'b1);
`ifdef UART_RX_FRAME_CHECK_EN
        if (bus.ferr === 1'b1) ferr_cnt++;
`endif
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bt;
        logic [7:0] exp_data;
        int         exp_dval;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] msg[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 8'hxx;
    endfunction

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    // Line stays at the stop value afterwards; callers release it
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bt);
        end
        rx = stop;
        #(bt);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n0, f0, c0, lat;

        vecs[0] = '{8'hA5, 1'b1, 100, 8'hA5, 1, 0};
        vecs[1] = '{8'h5A, 1'b1,  97, 8'h5A, 1, 0};
        vecs[2] = '{8'hC3, 1'b1, 103, 8'hC3, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 100, 8'h01, 1, 0};
        vecs[4] = '{8'h80, 1'b1,  97, 8'h80, 1, 0};
`ifdef UART_RX_FRAME_CHECK_EN
        vecs[5] = '{8'h3C, 1'b0, 100, 8'h80, 0, 1};
`else
        vecs[5] = '{8'h3C, 1'b0, 100, 8'h3C, 1, 0};
`endif
        vecs[6] = '{8'hE7, 1'b1, 103, 8'hE7, 1, 0};
        msg = '{8'h45, 8'h4E, 8'h47, 8'h32, 8'h30, 8'h30,
                8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'hFF};

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", bus.tdata, 8'h00);
        check("reset_dval", bus.tvalid, 1'b0);
`ifdef UART_RX_FRAME_CHECK_EN
        check("reset_ferr", bus.ferr, 1'b0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        idle(5);

        for (int v = 0; v < 7; v++) begin
            n0 = dval_cnt;
            f0 = ferr_cnt;
            align();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].bt);
            idle(30);
            check($sformatf("vec%0d_dval", v), dval_cnt - n0, vecs[v].exp_dval);
            check($sformatf("vec%0d_data", v), bus.tdata, vecs[v].exp_data);
`ifdef UART_RX_FRAME_CHECK_EN
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
`endif
        end

        // Latency from start-bit falling edge to strobe
        align();
        c0 = cyc;
        send_frame(8'hA5, 1'b1, 100);
        idle(30);
        lat = last_dval_cyc - c0;
        check("latency_window", (lat >= 95 && lat <= 100), 1);
        check("latency_data", bus.tdata, 8'hA5);

        // Back-to-back, no idle gap
        got.delete();
        n0 = dval_cnt;
        align();
        send_frame(8'h00, 1'b1, 100);
        send_frame(8'hFF, 1'b1, 100);
        idle(30);
        check("b2b_count", dval_cnt - n0, 2);
        check("b2b_byte0", got_at(0), 8'h00);
        check("b2b_byte1", got_at(1), 8'hFF);

        // Three-clock glitch, then a real frame right behind it
        n0 = dval_cnt;
        f0 = ferr_cnt;
        align();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #2 rx = 1'b1;
        idle(30);
        check("glitch_dval", dval_cnt - n0, 0);
        check("glitch_data", bus.tdata, 8'hFF);
`ifdef UART_RX_FRAME_CHECK_EN
        check("glitch_ferr", ferr_cnt - f0, 0);
`endif
        align();
        send_frame(8'h55, 1'b1, 100);
        idle(30);
        check("post_glitch_dval", dval_cnt - n0, 1);
        check("post_glitch_data", bus.tdata, 8'h55);

        // Bad stop bit followed by a held-low break
        n0 = dval_cnt;
        f0 = ferr_cnt;
        align();
        send_frame(8'h3C, 1'b0, 100);
        repeat (50) @(posedge clk);
        @(negedge clk);
`ifdef UART_RX_FRAME_CHECK_EN
        check("break_low_dval", dval_cnt - n0, 0);
        check("break_low_ferr", ferr_cnt - f0, 1);
`else
        check("break_low_dval", dval_cnt - n0, 1);
`endif
        idle(40);
`ifdef UART_RX_FRAME_CHECK_EN
        check("break_dval", dval_cnt - n0, 0);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_data", bus.tdata, 8'h55);
`else
        check("break_dval", dval_cnt - n0, 1);
        check("break_data", bus.tdata, 8'h3C);
`endif

        // Reset in the middle of data bit 4 of 0x81
        n0 = dval_cnt;
        f0 = ferr_cnt;
        align();
        rx = 1'b0;
        #100;
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            #100;
        end
        rx = 1'b0;
        #50;
        @(posedge clk);
        #1 reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset_data", bus.tdata, 8'h00);
        check("midreset_dval", bus.tvalid, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(120);
        check("midreset_nostrobe", dval_cnt - n0, 0);
        check("midreset_hold", bus.tdata, 8'h00);
`ifdef UART_RX_FRAME_CHECK_EN
        check("midreset_ferr", ferr_cnt - f0, 0);
`endif
        align();
        send_frame(8'h42, 1'b1, 100);
        idle(30);
        check("after_reset_dval", dval_cnt - n0, 1);
        check("after_reset_data", bus.tdata, 8'h42);

        // Message stream at both rate extremes
        for (int r = 0; r < 2; r++) begin
            got.delete();
            n0 = dval_cnt;
            align();
            for (int i = 0; i < 12; i++) begin
                send_frame(msg[i], 1'b1, (r == 0) ? 97 : 103);
            end
            idle(30);
            check($sformatf("msg%0d_count", r), dval_cnt - n0, 12);
            for (int i = 0; i < 12; i++) begin
                check($sformatf("msg%0d_byte%0d", r, i), got_at(i), msg[i]);
            end
        end

        check("dval_single_cycle", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
